dmem_access: RTL and testbench

Data-memory responder that sits after the EX/MEM-WB pipeline register and services the load/store request that register presents. It converts each request into a single req/ack transaction on the data bus, generates byte enables and write-data lane replication, sign/zero-extends load data for writeback, and raises a hold request to the pipeline controller while a transaction is outstanding.

---
 rtl/dmem_access_if.sv | 39 +++
 rtl/dmem_access.sv | 233 +++++++++++++++++++++++
 tb/tb_dmem_access.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_if.sv
// dmem_access_if: single-transaction req/ack data bus between the
// data-memory responder (master) and the memory/bus fabric (slave).
// Signals:
//   bus_req   master->slave  transaction request, held until ack
//   bus_we    master->slave  1 write, 0 read
//   bus_addr  master->slave  word address, bits [1:0] zero
//   bus_be    master->slave  byte enables
//   bus_wdata master->slave  lane-replicated write data
//   bus_ack   slave->master  transaction complete
//   bus_rdata slave->master  read word, valid with bus_ack
interface dmem_access_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req,
      output bus_we,
      output bus_addr,
      output bus_be,
      output bus_wdata,
      input  bus_ack,
      input  bus_rdata
   );

   modport slave (
      input  bus_req,
      input  bus_we,
      input  bus_addr,
      input  bus_be,
      input  bus_wdata,
      output bus_ack,
      output bus_rdata
   );
endinterface

// File: rtl/dmem_access.sv
// dmem_access: services the load/store presented by the EX/MEM-WB
// register as one req/ack bus transaction; builds byte enables and
// replicated write data, extends load data, stalls the pipe meanwhile.
// Ports:
//   clk, rst            core clock, async active-high reset
//   w_mem_enable_i      store request (wins over a load)
//   w_mem_addr_i/data_i store byte address / right-aligned data
//   r_mem_enable_i      load request
//   r_mem_addr_i        load byte address
//   data_type_i         1 sb,2 sh,3 w,4 ub,5 uh; others none
//   bus                 dmem_access_if.master data bus
//   r_mem_data_o        extended load result, held between pulses
//   r_mem_valid_o       one-cycle load-result pulse
//   hold_req_o          stall request to the pipeline controller
//   misalign_o          one-cycle pulse: misaligned access dropped
//   timeout_o           one-cycle pulse: transaction aborted
// Optional feature: define DMEM_TIMEOUT_EN to abort a BUSY transaction
// after TIMEOUT_CYCLES cycles without ack; otherwise timeout_o is 0.
module dmem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          w_mem_enable_i,
   input  logic [31:0]   w_mem_addr_i,
   input  logic [31:0]   w_mem_data_i,
   input  logic          r_mem_enable_i,
   input  logic [31:0]   r_mem_addr_i,
   input  logic [2:0]    data_type_i,
   dmem_access_if.master bus,
   output logic [31:0]   r_mem_data_o,
   output logic          r_mem_valid_o,
   output logic          hold_req_o,
   output logic          misalign_o,
   output logic          timeout_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   state_t      r_state;
   logic        r_bus_req;
   logic        r_we;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   logic [31:0] r_wdata;
   logic [2:0]  r_type;
   logic [1:0]  r_off;
   logic [31:0] r_mem_data;
   logic        r_valid;
   logic        r_misalign;

   logic        w_is_store;
   logic [31:0] w_addr;
   logic [1:0]  w_off;
   logic        w_type_ok;
   logic        w_is_byte;
   logic        w_is_half;
   logic        w_is_word;
   logic        w_misal;
   logic        w_req;
   logic        w_start;
   logic        w_drop;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;

   // A store has priority when both enables are raised together.
   assign w_is_store = w_mem_enable_i;
   assign w_addr     = w_is_store ? w_mem_addr_i : r_mem_addr_i;
   assign w_off      = w_addr[1:0];

   assign w_type_ok = (data_type_i >= 3'd1) && (data_type_i <= 3'd5);
   assign w_is_byte = (data_type_i == 3'd1) || (data_type_i == 3'd4);
   assign w_is_half = (data_type_i == 3'd2) || (data_type_i == 3'd5);
   assign w_is_word = (data_type_i == 3'd3);

   assign w_misal = (w_is_half & w_off[0])
                  | (w_is_word & (w_off != 2'b00));

   // Gating with rst keeps hold low while the pipeline is being reset.
   assign w_req = (w_mem_enable_i | r_mem_enable_i)
                & w_type_ok
                & (r_state == ST_IDLE)
                & ~rst;

   assign w_start = w_req & ~w_misal;
   assign w_drop  = w_req & w_misal;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = w_mem_data_i;
      unique case (1'b1)
         w_is_byte: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{w_mem_data_i[7:0]}};
         end
         w_is_half: begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{w_mem_data_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = w_mem_data_i;
         end
      endcase
   end

   // Select the addressed lane and extend it to 32 bits.
   function automatic logic [31:0] f_extend(
      input logic [31:0] d,
      input logic [1:0]  off,
      input logic [2:0]  dt
   );
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = d >> {off, 3'b000};
      b  = sh[7:0];
      h  = off[1] ? d[31:16] : d[15:0];
      case (dt)
         3'd1:    f_extend = {{24{b[7]}}, b};
         3'd2:    f_extend = {{16{h[15]}}, h};
         3'd4:    f_extend = {24'd0, b};
         3'd5:    f_extend = {16'd0, h};
         default: f_extend = d;
      endcase
   endfunction

`ifdef DMEM_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_timeout;
`else
   logic w_unused_tmo;
   assign w_unused_tmo = |TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bus_req  <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= 32'd0;
         r_be       <= 4'd0;
         r_wdata    <= 32'd0;
         r_type     <= 3'd0;
         r_off      <= 2'd0;
         r_mem_data <= 32'd0;
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         r_cnt      <= '0;
         r_timeout  <= 1'b0;
`endif
      end else begin
         r_valid    <= 1'b0;
         r_misalign <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         r_timeout  <= 1'b0;
`endif
         unique case (r_state)
            ST_IDLE: begin
               if (w_drop) begin
                  r_misalign <= 1'b1;
               end
               if (w_start) begin
                  r_we      <= w_is_store;
                  r_addr    <= {w_addr[31:2], 2'b00};
                  r_be      <= w_be;
                  r_wdata   <= w_wdata;
                  r_type    <= data_type_i;
                  r_off     <= w_off;
                  r_bus_req <= 1'b1;
                  r_state   <= ST_BUSY;
`ifdef DMEM_TIMEOUT_EN
                  r_cnt     <= '0;
`endif
               end
            end
            ST_BUSY: begin
               // Ack wins over a terminal count in the same cycle.
               if (bus.bus_ack) begin
                  r_bus_req <= 1'b0;
                  r_state   <= ST_RESP;
                  if (!r_we) begin
                     r_mem_data <= f_extend(bus.bus_rdata, r_off, r_type);
                     r_valid    <= 1'b1;
                  end
               end
`ifdef DMEM_TIMEOUT_EN
               else if (r_cnt == TC_LAST) begin
                  r_bus_req <= 1'b0;
                  r_timeout <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_bus_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus.bus_req   = r_bus_req;
   assign bus.bus_we    = r_we;
   assign bus.bus_addr  = r_addr;
   assign bus.bus_be    = r_be;
   assign bus.bus_wdata = r_wdata;

   assign r_mem_data_o  = r_mem_data;
   assign r_mem_valid_o = r_valid;
   assign misalign_o    = r_misalign;
   assign hold_req_o    = w_start | r_bus_req;

`ifdef DMEM_TIMEOUT_EN
   assign timeout_o = r_timeout;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: table-driven vectors plus hand-written reset and
// timeout sequences; load results checked through a scoreboard queue.
module tb_dmem_access;

   localparam int unsigned TMO = 4;

   logic        clk;
   logic        rst;
   logic        w_mem_enable;
   logic [31:0] w_mem_addr;
   logic [31:0] w_mem_data;
   logic        r_mem_enable;
   logic [31:0] r_mem_addr;
   logic [2:0]  data_type;
   logic [31:0] r_mem_data;
   logic        r_mem_valid;
   logic        hold_req;
   logic        misalign;
   logic        timeout;

   dmem_access_if bus_if ();

   dmem_access #(
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .w_mem_enable_i (w_mem_enable),
      .w_mem_addr_i   (w_mem_addr),
      .w_mem_data_i   (w_mem_data),
      .r_mem_enable_i (r_mem_enable),
      .r_mem_addr_i   (r_mem_addr),
      .data_type_i    (data_type),
      .bus            (bus_if),
      .r_mem_data_o   (r_mem_data),
      .r_mem_valid_o  (r_mem_valid),
      .hold_req_o     (hold_req),
      .misalign_o     (misalign),
      .timeout_o      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        ld;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [2:0]  dt;
      int          waits;
      logic [31:0] rdat;
      int          kind;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_data;
   } vec_t;

   int checks;
   int failures;
   logic [31:0] exp_q[$];
   logic [31:0] last_data;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Scoreboard: every load result pulse pops one expected value.
   always @(negedge clk) begin
      if (r_mem_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_valid actual=%h required=none",
                     r_mem_data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (r_mem_data !== e) begin
               failures++;
               $display("FAIL sb_load_data actual=%h required=%h",
                        r_mem_data, e);
            end
         end
      end
   end

   function automatic vec_t mk(
      input logic st, input logic ld, input logic [31:0] addr,
      input logic [31:0] wdat, input logic [2:0] dt, input int waits,
      input logic [31:0] rdat, input int kind,
      input logic [31:0] ea, input logic [3:0] eb,
      input logic [31:0] ew, input logic [31:0] ed);
      vec_t v;
      v.st = st; v.ld = ld; v.addr = addr; v.wdat = wdat;
      v.dt = dt; v.waits = waits; v.rdat = rdat; v.kind = kind;
      v.exp_addr = ea; v.exp_be = eb; v.exp_wdata = ew;
      v.exp_data = ed;
      return v;
   endfunction

   task automatic drive_req(input vec_t v);
      w_mem_enable = v.st;
      r_mem_enable = v.ld;
      w_mem_addr   = v.st ? v.addr : 32'h0;
      r_mem_addr   = v.addr;
      w_mem_data   = v.wdat;
      data_type    = v.dt;
   endtask

   task automatic idle_req();
      w_mem_enable = 1'b0;
      r_mem_enable = 1'b0;
      data_type    = 3'd0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string nm;
      nm = $sformatf("v%0d", idx);
      @(negedge clk);
      drive_req(v);
      #1;
      chk({nm, "_hold_n"}, 32'(hold_req), 32'(v.kind == 0));
      if (v.kind != 0) begin
         @(negedge clk);
         idle_req();
         chk({nm, "_misal"}, 32'(misalign), 32'(v.kind == 1));
         chk({nm, "_noreq"}, 32'(bus_if.bus_req), 32'd0);
         chk({nm, "_nohold"}, 32'(hold_req), 32'd0);
         @(negedge clk);
         chk({nm, "_misal_end"}, 32'(misalign), 32'd0);
         return;
      end
      if (!v.st) begin
         exp_q.push_back(v.exp_data);
      end
      for (int i = 0; i <= v.waits; i++) begin
         @(negedge clk);
         bus_if.bus_ack = 1'b0;
         chk({nm, "_req"}, 32'(bus_if.bus_req), 32'd1);
         chk({nm, "_hold"}, 32'(hold_req), 32'd1);
         chk({nm, "_we"}, 32'(bus_if.bus_we), 32'(v.st));
         chk({nm, "_addr"}, bus_if.bus_addr, v.exp_addr);
         if (v.st) begin
            chk({nm, "_be"}, 32'(bus_if.bus_be), 32'(v.exp_be));
            chk({nm, "_wdata"}, bus_if.bus_wdata, v.exp_wdata);
         end
         if (i == v.waits) begin
            bus_if.bus_ack   = 1'b1;
            bus_if.bus_rdata = v.rdat;
         end
      end
      @(negedge clk);
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 32'h5A5A_5A5A;
      chk({nm, "_resp_req"}, 32'(bus_if.bus_req), 32'd0);
      chk({nm, "_resp_hold"}, 32'(hold_req), 32'd0);
      chk({nm, "_valid"}, 32'(r_mem_valid), 32'(!v.st));
      if (v.st) begin
         chk({nm, "_data_held"}, r_mem_data, last_data);
      end else begin
         last_data = v.exp_data;
      end
      idle_req();
      @(negedge clk);
      chk({nm, "_valid_end"}, 32'(r_mem_valid), 32'd0);
      chk({nm, "_tmo"}, 32'(timeout), 32'd0);
   endtask

   vec_t vt[13];

   initial begin
      checks    = 0;
      failures  = 0;
      last_data = 32'd0;

      vt[0]  = mk(0, 1, 32'h100, 32'h0, 3'd3, 2, 32'hDEADBEEF, 0,
                  32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
      vt[1]  = mk(0, 1, 32'h103, 32'h0, 3'd1, 0, 32'h80112233, 0,
                  32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
      vt[2]  = mk(0, 1, 32'h103, 32'h0, 3'd4, 1, 32'h80112233, 0,
                  32'h100, 4'b1000, 32'h0, 32'h00000080);
      vt[3]  = mk(1, 0, 32'h202, 32'h0000ABCD, 3'd2, 1, 32'h0, 0,
                  32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
      vt[4]  = mk(0, 1, 32'h102, 32'h0, 3'd3, 0, 32'h0, 1,
                  32'h0, 4'b0, 32'h0, 32'h0);
      vt[5]  = mk(0, 1, 32'h102, 32'h0, 3'd2, 3, 32'h80017FFF, 0,
                  32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
      vt[6]  = mk(0, 1, 32'h100, 32'h0, 3'd5, 0, 32'h1234F00D, 0,
                  32'h100, 4'b0011, 32'h0, 32'h0000F00D);
      vt[7]  = mk(1, 0, 32'h301, 32'h123456A5, 3'd1, 0, 32'h0, 0,
                  32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0);
      vt[8]  = mk(1, 0, 32'h404, 32'hCAFEF00D, 3'd3, 2, 32'h0, 0,
                  32'h404, 4'b1111, 32'hCAFEF00D, 32'h0);
      vt[9]  = mk(1, 1, 32'h500, 32'h11223344, 3'd3, 0, 32'h0, 0,
                  32'h500, 4'b1111, 32'h11223344, 32'h0);
      vt[10] = mk(1, 0, 32'h203, 32'h0000BEEF, 3'd2, 0, 32'h0, 1,
                  32'h0, 4'b0, 32'h0, 32'h0);
      vt[11] = mk(0, 1, 32'h101, 32'h0, 3'd1, 0, 32'h00007F00, 0,
                  32'h100, 4'b0010, 32'h0, 32'h0000007F);
      vt[12] = mk(0, 1, 32'h100, 32'h0, 3'd6, 0, 32'h0, 2,
                  32'h0, 4'b0, 32'h0, 32'h0);

      rst              = 1'b1;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 32'h0;
      w_mem_data       = 32'h0;
      w_mem_addr       = 32'h0;
      r_mem_addr       = 32'h0;
      idle_req();

      @(negedge clk);
      chk("rst_req", 32'(bus_if.bus_req), 32'd0);
      chk("rst_hold", 32'(hold_req), 32'd0);
      chk("rst_valid", 32'(r_mem_valid), 32'd0);
      chk("rst_data", r_mem_data, 32'd0);
      chk("rst_misal", 32'(misalign), 32'd0);
      chk("rst_tmo", 32'(timeout), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_vec(i, vt[i]);
      end

      // Reset while BUSY, then a stray late ack.
      @(negedge clk);
      drive_req(vt[0]);
      exp_q.delete();
      @(negedge clk);
      chk("mid_req_busy", 32'(bus_if.bus_req), 32'd1);
      #2;
      rst = 1'b1;
      idle_req();
      #1;
      chk("mid_req_drop", 32'(bus_if.bus_req), 32'd0);
      chk("mid_hold_drop", 32'(hold_req), 32'd0);
      chk("mid_valid", 32'(r_mem_valid), 32'd0);
      chk("mid_data_rst", r_mem_data, 32'd0);
      @(negedge clk);
      rst              = 1'b0;
      bus_if.bus_ack   = 1'b1;
      bus_if.bus_rdata = 32'h12345678;
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      chk("late_ack_req", 32'(bus_if.bus_req), 32'd0);
      chk("late_ack_valid", 32'(r_mem_valid), 32'd0);
      @(negedge clk);
      chk("late_ack_valid2", 32'(r_mem_valid), 32'd0);
      last_data = 32'd0;
      run_vec(13, vt[0]);

`ifdef DMEM_TIMEOUT_EN
      // No ack: abort after TMO busy cycles.
      @(negedge clk);
      drive_req(vt[0]);
      for (int k = 0; k < int'(TMO); k++) begin
         @(negedge clk);
         chk("tmo_busy_req", 32'(bus_if.bus_req), 32'd1);
         chk("tmo_busy_flag", 32'(timeout), 32'd0);
         if (k == int'(TMO) - 1) begin
            idle_req();
         end
      end
      @(negedge clk);
      chk("tmo_pulse", 32'(timeout), 32'd1);
      chk("tmo_req_drop", 32'(bus_if.bus_req), 32'd0);
      chk("tmo_hold_rel", 32'(hold_req), 32'd0);
      chk("tmo_no_valid", 32'(r_mem_valid), 32'd0);
      @(negedge clk);
      chk("tmo_pulse_end", 32'(timeout), 32'd0);
      chk("tmo_idle_req", 32'(bus_if.bus_req), 32'd0);
      run_vec(14, vt[5]);
`endif

      @(negedge clk);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
